// File: rtl/hwpe_ctrl_job_offloader.sv
// rtl/hwpe_ctrl_job_offloader.sv - offloads one job descriptor to an HWPE control target port
module hwpe_ctrl_job_offloader #(
  parameter int unsigned N_IO_REGS       = 2,
  parameter int unsigned ID_WIDTH        = 16,
  parameter logic [31:0] IO_BASE_OFFSET  = 32'h40,
  parameter logic [31:0] ACQUIRE_OFFSET  = 32'h04,
  parameter logic [31:0] TRIGGER_OFFSET  = 32'h00,
  parameter logic [31:0] FINISHED_OFFSET = 32'h08,
  parameter int unsigned BACKOFF_CYCLES  = 8,
  parameter int unsigned MAX_RETRY       = 0,
  parameter int unsigned OWN_ID          = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic [31:0]             base_addr_i,
  input  logic                    job_valid_i,
  output logic                    job_ready_o,
  input  logic [N_IO_REGS*32-1:0] job_regs_i,
  output logic                    job_done_o,
  output logic                    job_error_o,
  output logic [7:0]              job_id_o,
  output logic [1:0]              finished_cnt_o,
  input  logic                    evt_i,
  output logic                    busy_o,
  output logic                    periph_req_o,
  input  logic                    periph_gnt_i,
  output logic [31:0]             periph_add_o,
  output logic                    periph_wen_o,
  output logic [3:0]              periph_be_o,
  output logic [31:0]             periph_data_o,
  output logic [ID_WIDTH-1:0]     periph_id_o,
  input  logic [31:0]             periph_r_data_i,
  input  logic                    periph_r_valid_i,
  input  logic [ID_WIDTH-1:0]     periph_r_id_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_ACQ, S_ACQ_WAIT, S_BACKOFF, S_WR, S_WR_WAIT,
    S_TRIG, S_TRIG_WAIT, S_EVT, S_FIN, S_FIN_WAIT
  } state_e;

  state_e                  state_q, state_d;
  logic [N_IO_REGS*32-1:0] regs_q;
  logic [31:0]             base_q;
  logic [31:0]             retry_q;
  logic [31:0]             backoff_q;
  logic [5:0]              k_q;
  logic [7:0]              job_id_q;
  logic [1:0]              fin_q;
  logic                    evt_seen_q;

  logic        rst_any;
  logic        refused;
  logic        retry_exhausted;
  logic        last_reg;
  logic [31:0] wr_data;
  logic        unused_inputs;

  assign rst_any         = rst_i | clear_i;
  // Any negative acquire value means no context was handed out.
  assign refused         = periph_r_data_i[31];
  assign retry_exhausted = (MAX_RETRY != 0) && ((retry_q + 32'd1) == MAX_RETRY);
  assign last_reg        = (k_q == 6'(N_IO_REGS - 1));
  assign wr_data         = 32'(regs_q >> {k_q, 5'b00000});
  assign unused_inputs   = ^{periph_r_id_i, periph_r_data_i[30:8]};

  always_comb begin
    state_d       = state_q;
    periph_req_o  = 1'b0;
    periph_wen_o  = 1'b1;
    periph_add_o  = 32'h0;
    periph_data_o = 32'h0;
    job_done_o    = 1'b0;
    job_error_o   = 1'b0;
    unique case (state_q)
      S_IDLE: if (job_valid_i) state_d = S_ACQ;
      S_ACQ: begin
        periph_req_o = 1'b1;
        periph_add_o = base_q + ACQUIRE_OFFSET;
        if (periph_gnt_i) state_d = S_ACQ_WAIT;
      end
      S_ACQ_WAIT: if (periph_r_valid_i) begin
        if (!refused) begin
          state_d = S_WR;
        end else if (retry_exhausted) begin
          job_error_o = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_BACKOFF;
        end
      end
      S_BACKOFF: if (backoff_q == BACKOFF_CYCLES - 1) state_d = S_ACQ;
      S_WR: begin
        periph_req_o  = 1'b1;
        periph_wen_o  = 1'b0;
        periph_add_o  = base_q + IO_BASE_OFFSET + {24'h0, k_q, 2'b00};
        periph_data_o = wr_data;
        if (periph_gnt_i) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: if (periph_r_valid_i) state_d = last_reg ? S_TRIG : S_WR;
      S_TRIG: begin
        periph_req_o = 1'b1;
        periph_wen_o = 1'b0;
        periph_add_o = base_q + TRIGGER_OFFSET;
        if (periph_gnt_i) state_d = S_TRIG_WAIT;
      end
      S_TRIG_WAIT: if (periph_r_valid_i) state_d = S_EVT;
      S_EVT: if (evt_i || evt_seen_q) state_d = S_FIN;
      S_FIN: begin
        periph_req_o = 1'b1;
        periph_add_o = base_q + FINISHED_OFFSET;
        if (periph_gnt_i) state_d = S_FIN_WAIT;
      end
      S_FIN_WAIT: if (periph_r_valid_i) begin
        job_done_o = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_any) begin
      state_q    <= S_IDLE;
      regs_q     <= '0;
      base_q     <= 32'h0;
      retry_q    <= 32'h0;
      backoff_q  <= 32'h0;
      k_q        <= 6'h0;
      job_id_q   <= 8'h0;
      fin_q      <= 2'h0;
      evt_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: if (job_valid_i) begin
          regs_q     <= job_regs_i;
          base_q     <= base_addr_i;
          retry_q    <= 32'h0;
          evt_seen_q <= 1'b0;
        end
        S_ACQ_WAIT: if (periph_r_valid_i) begin
          if (refused) begin
            retry_q   <= retry_q + 32'd1;
            backoff_q <= 32'h0;
          end else begin
            job_id_q <= periph_r_data_i[7:0];
            k_q      <= 6'h0;
          end
        end
        S_BACKOFF: backoff_q <= backoff_q + 32'd1;
        S_WR_WAIT: if (periph_r_valid_i) k_q <= k_q + 6'd1;
        // The event may beat the trigger write response; remember it.
        S_TRIG_WAIT: if (evt_i) evt_seen_q <= 1'b1;
        S_FIN_WAIT: if (periph_r_valid_i) fin_q <= periph_r_data_i[1:0];
        default: ;
      endcase
    end
  end

  assign job_ready_o    = (state_q == S_IDLE);
  assign busy_o         = (state_q != S_IDLE);
  assign job_id_o       = job_id_q;
  assign finished_cnt_o = job_done_o ? periph_r_data_i[1:0] : fin_q;
  assign periph_be_o    = 4'hF;
  assign periph_id_o    = ID_WIDTH'(OWN_ID);

endmodule

// File: tb/tb_hwpe_ctrl_job_offloader.sv
// tb/tb_hwpe_ctrl_job_offloader.sv - scoreboard bench with a target-port model for the job offloader
module tb_hwpe_ctrl_job_offloader;

  logic        clk_i = 1'b0;
  logic        rst_i, clear_i;
  logic [31:0] base_addr_i;
  logic        job_valid_i, job_ready_o;
  logic [63:0] job_regs_i;
  logic        job_done_o, job_error_o;
  logic [7:0]  job_id_o;
  logic [1:0]  finished_cnt_o;
  logic        evt_i, busy_o;
  logic        periph_req_o, periph_gnt_i;
  logic [31:0] periph_add_o;
  logic        periph_wen_o;
  logic [3:0]  periph_be_o;
  logic [31:0] periph_data_o;
  logic [15:0] periph_id_o;
  logic [31:0] periph_r_data_i;
  logic        periph_r_valid_i;
  logic [15:0] periph_r_id_i;

  hwpe_ctrl_job_offloader #(
    .N_IO_REGS(2), .ID_WIDTH(16), .BACKOFF_CYCLES(8), .MAX_RETRY(3), .OWN_ID(0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .base_addr_i(base_addr_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_regs_i(job_regs_i),
    .job_done_o(job_done_o), .job_error_o(job_error_o), .job_id_o(job_id_o),
    .finished_cnt_o(finished_cnt_o), .evt_i(evt_i), .busy_o(busy_o),
    .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i), .periph_add_o(periph_add_o),
    .periph_wen_o(periph_wen_o), .periph_be_o(periph_be_o), .periph_data_o(periph_data_o),
    .periph_id_o(periph_id_o), .periph_r_data_i(periph_r_data_i),
    .periph_r_valid_i(periph_r_valid_i), .periph_r_id_i(periph_r_id_i)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [31:0] base, reg0, reg1;
    int          n_acq;
    logic [31:0] acq0, acq1, acq2;
    logic [31:0] fin;
    int          gnt_dly, rv_dly;
    bit          evt_early, exp_err;
    logic [7:0]  exp_id;
    logic [1:0]  exp_fin;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  txn_t        exp_q[$];
  logic [31:0] acq_q[$];
  int          gap_q[$];

  int          cyc = 0, gnt_dly = 0, rv_dly = 0, evt_at = -1;
  int          rv_wait = 0, gnt_wait = 0, rise_cyc = 0, last_rv_cyc = 0;
  bit          outst = 0, req_prev = 0, prev_refused = 0, resp_trig = 0, evt_early = 0;
  logic [31:0] prev_add, prev_data, resp_data, cur_base, fin_val;
  logic        prev_wen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Target port model: grant/response delays, acquire/finished replies, event generation.
  initial begin
    txn_t e;
    periph_gnt_i = 0; periph_r_valid_i = 0; periph_r_data_i = 0; periph_r_id_i = 0; evt_i = 0;
    forever begin
      @(posedge clk_i); #1;
      cyc++;
      periph_gnt_i = 0; periph_r_valid_i = 0; evt_i = 0;
      if (job_ready_o) prev_refused = 0;
      if (cyc == evt_at) evt_i = 1;
      if (outst) begin
        chk("one_outstanding", 32'(periph_req_o), 32'd0);
        if (rv_wait >= rv_dly) begin
          periph_r_valid_i = 1; periph_r_data_i = resp_data; outst = 0; last_rv_cyc = cyc;
          if (resp_trig && !evt_early) evt_at = cyc + 2;
        end else rv_wait++;
        req_prev = 0; gnt_wait = 0;
      end else if (periph_req_o) begin
        if (req_prev) begin
          chk("stable_add", periph_add_o, prev_add);
          chk("stable_wen", 32'(periph_wen_o), 32'(prev_wen));
          chk("stable_data", periph_data_o, prev_data);
        end else rise_cyc = cyc;
        if (gnt_wait >= gnt_dly) begin
          periph_gnt_i = 1; req_prev = 0; gnt_wait = 0;
          chk("be", 32'(periph_be_o), 32'hF);
          chk("periph_id", 32'(periph_id_o), 32'd0);
          if (periph_wen_o && periph_add_o == cur_base + 32'h4) begin
            if (prev_refused) gap_q.push_back(rise_cyc - last_rv_cyc - 1);
            resp_data = (acq_q.size() > 0) ? acq_q.pop_front() : 32'hFFFF_FFFF;
            prev_refused = resp_data[31];
          end else if (periph_wen_o && periph_add_o == cur_base + 32'h8) resp_data = fin_val;
          else resp_data = 32'h0;
          resp_trig = !periph_wen_o && periph_add_o == cur_base;
          if (resp_trig && evt_early) evt_at = cyc + 1;
          outst = 1; rv_wait = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_txn_add", periph_add_o, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("txn_add", periph_add_o, e.addr);
            chk("txn_wen", 32'(periph_wen_o), 32'(e.wen));
            if (!e.wen) chk("txn_data", periph_data_o, e.data);
          end
        end else begin
          gnt_wait++; req_prev = 1;
          prev_add = periph_add_o; prev_wen = periph_wen_o; prev_data = periph_data_o;
        end
      end else begin
        req_prev = 0; gnt_wait = 0;
      end
    end
  end

  function automatic vec_t mk(input logic [31:0] base, r0, r1, input int n,
                              input logic [31:0] a0, a1, a2, fin, input int gd, rd,
                              input bit early, err, input logic [7:0] id, input logic [1:0] fc);
    vec_t v;
    v.base = base; v.reg0 = r0; v.reg1 = r1; v.n_acq = n;
    v.acq0 = a0; v.acq1 = a1; v.acq2 = a2; v.fin = fin;
    v.gnt_dly = gd; v.rv_dly = rd; v.evt_early = early; v.exp_err = err;
    v.exp_id = id; v.exp_fin = fc;
    return v;
  endfunction

  task automatic load(input vec_t v);
    cur_base = v.base; gnt_dly = v.gnt_dly; rv_dly = v.rv_dly;
    fin_val = v.fin; evt_early = v.evt_early;
    acq_q.delete(); gap_q.delete(); exp_q.delete();
    for (int i = 0; i < v.n_acq; i++) begin
      acq_q.push_back(i == 0 ? v.acq0 : (i == 1 ? v.acq1 : v.acq2));
      exp_q.push_back('{v.base + 32'h4, 1'b1, 32'h0});
    end
    if (!v.exp_err) begin
      exp_q.push_back('{v.base + 32'h40, 1'b0, v.reg0});
      exp_q.push_back('{v.base + 32'h44, 1'b0, v.reg1});
      exp_q.push_back('{v.base, 1'b0, 32'h0});
      exp_q.push_back('{v.base + 32'h8, 1'b1, 32'h0});
    end
  endtask

  task automatic drive_job(input vec_t v);
    int t = 0;
    while (!job_ready_o && t < 100) begin @(negedge clk_i); t++; end
    base_addr_i = v.base; job_regs_i = {v.reg1, v.reg0}; job_valid_i = 1;
    @(negedge clk_i);
    job_valid_i = 0; base_addr_i = 32'hDEAD_0000; job_regs_i = '1;
  endtask

  task automatic run_job(input vec_t v);
    int t = 0;
    load(v);
    drive_job(v);
    while (!(job_done_o || job_error_o) && t < 3000) begin @(negedge clk_i); t++; end
    chk("job_no_timeout", 32'(t < 3000), 32'd1);
    chk("done_pulse", 32'(job_done_o), 32'(!v.exp_err));
    chk("error_pulse", 32'(job_error_o), 32'(v.exp_err));
    chk("ready_low_at_end", 32'(job_ready_o), 32'd0);
    if (!v.exp_err) begin
      chk("finished_cnt", 32'(finished_cnt_o), 32'(v.exp_fin));
      chk("job_id", 32'(job_id_o), 32'(v.exp_id));
    end
    @(negedge clk_i);
    chk("done_one_cycle", 32'(job_done_o), 32'd0);
    chk("error_one_cycle", 32'(job_error_o), 32'd0);
    chk("ready_after", 32'(job_ready_o), 32'd1);
    chk("busy_after", 32'(busy_o), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("backoff_gap_count", 32'(gap_q.size()), 32'(v.n_acq - 1));
    foreach (gap_q[i]) chk("backoff_gap_len", 32'(gap_q[i]), 32'd8);
    if (t >= 3000) begin
      rst_i = 1; @(negedge clk_i); rst_i = 0;
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    int   t;
    rst_i = 1; clear_i = 0; job_valid_i = 0; base_addr_i = 0; job_regs_i = 0;
    vecs[0] = mk(32'h1A20_0000, 32'hAAAA_0001, 32'h0000_BEEF, 1, 32'd3, 0, 0, 32'd1, 0, 0, 0, 0, 8'd3, 2'd1);
    vecs[1] = mk(32'h1A20_0000, 32'h1111_1111, 32'h2222_2222, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd5,
                 32'd2, 0, 0, 0, 0, 8'd5, 2'd2);
    vecs[2] = mk(32'h1A20_0000, 32'h3, 32'h4, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'd0, 0, 0, 0, 1, 8'd0, 2'd0);
    vecs[3] = mk(32'h1A20_0000, 32'hAAAA_0001, 32'h0000_BEEF, 1, 32'd3, 0, 0, 32'd1, 4, 3, 0, 0, 8'd3, 2'd1);
    vecs[4] = mk(32'hFFFF_FFF0, 32'hCAFE_F00D, 32'h1234_5678, 1, 32'h0000_0112, 0, 0, 32'h7,
                 0, 2, 1, 0, 8'h12, 2'd3);
    vecs[5] = mk(32'h0000_1000, 32'hFFFF_FFFF, 32'h0, 1, 32'h7FFF_FFFF, 0, 0, 32'h0, 1, 1, 0, 0, 8'hFF, 2'd0);
    vecs[6] = mk(32'h0000_2000, 32'h5, 32'h6, 2, 32'h8000_0000, 32'h0, 0, 32'h2, 0, 1, 1, 0, 8'h00, 2'd2);

    repeat (3) @(negedge clk_i);
    chk("rst_ready", 32'(job_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_req", 32'(periph_req_o), 32'd0);
    chk("rst_done", 32'(job_done_o), 32'd0);
    chk("rst_error", 32'(job_error_o), 32'd0);
    chk("rst_job_id", 32'(job_id_o), 32'd0);
    chk("rst_finished", 32'(finished_cnt_o), 32'd0);
    rst_i = 0;
    @(negedge clk_i);

    evt_at = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("idle_evt_busy", 32'(busy_o), 32'd0);
      chk("idle_evt_req", 32'(periph_req_o), 32'd0);
    end

    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // Reset while the second IO write awaits its response.
    v = vecs[0]; v.rv_dly = 3;
    load(v);
    drive_job(v);
    t = 0;
    while (!(periph_req_o && periph_add_o == v.base + 32'h44) && t < 200) begin
      @(negedge clk_i); t++;
    end
    chk("rst_reach_wr1", 32'(t < 200), 32'd1);
    @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    chk("midrst_req", 32'(periph_req_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_ready", 32'(job_ready_o), 32'd1);
    rst_i = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("midrst_quiet_req", 32'(periph_req_o), 32'd0);
      chk("midrst_quiet_busy", 32'(busy_o), 32'd0);
    end
    run_job(vecs[0]);

    // Soft clear while the acquire is still waiting for its grant.
    v = vecs[0]; v.gnt_dly = 4;
    load(v);
    drive_job(v);
    chk("clr_acq_req", 32'(periph_req_o), 32'd1);
    clear_i = 1;
    @(negedge clk_i);
    chk("clr_req", 32'(periph_req_o), 32'd0);
    chk("clr_ready", 32'(job_ready_o), 32'd1);
    chk("clr_busy", 32'(busy_o), 32'd0);
    clear_i = 0;
    repeat (3) begin
      @(negedge clk_i);
      chk("clr_quiet_req", 32'(periph_req_o), 32'd0);
    end
    run_job(vecs[5]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
